// File: rtl/gshare_predictor.sv
// gshare branch direction predictor: PC XOR global history indexes a table of saturating counters.
// Optional hit/miss statistics are built when PRED_STATS_EN is defined.
module gshare_predictor #(
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned HIST_BITS  = 4,
  parameter int unsigned PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [PC_WIDTH-1:0]   req_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
`ifdef PRED_STATS_EN
  input  logic                  upd_pred,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt,
`endif
  output logic [HIST_BITS-1:0]  ghr
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

  logic [CTR_WIDTH-1:0]  ctr_q [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctr_d [ENTRIES];
  logic [HIST_BITS-1:0]  ghr_q, ghr_d, ghr_shift;
  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
  logic [INDEX_BITS-1:0] req_idx;
  logic                  unused_pc_bits;

  // Only the low PC bits participate in the hash.
  assign unused_pc_bits = ^req_pc;

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_shift = upd_taken;
    end else begin : g_histn
      assign ghr_shift = {ghr_q[HIST_BITS-2:0], upd_taken};
    end
  endgenerate

  // Lookup uses the registered history, so a same-cycle update never affects it.
  assign req_idx = req_pc[INDEX_BITS-1:0] ^ INDEX_BITS'(ghr_q);

  always_comb begin
    ctr_d        = ctr_q;
    ghr_d        = ghr_q;
    pred_valid_d = req_valid;
    pred_taken_d = pred_taken_q;
    pred_index_d = pred_index_q;
    if (upd_valid) begin
      ghr_d = ghr_shift;
      if (upd_taken) begin
        if (ctr_q[upd_index] != CTR_MAX) ctr_d[upd_index] = ctr_q[upd_index] + CTR_ONE;
      end else begin
        if (ctr_q[upd_index] != '0) ctr_d[upd_index] = ctr_q[upd_index] - CTR_ONE;
      end
    end
    if (req_valid) begin
      pred_taken_d = ctr_q[req_idx][CTR_WIDTH-1];
      pred_index_d = req_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= ctr_d[i];
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_index_q <= pred_index_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_index = pred_index_q;
  assign ghr        = ghr_q;

`ifdef PRED_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd_valid) begin
      if (upd_pred == upd_taken) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor (default parameters).
// Statistics checks are compiled in when PRED_STATS_EN is defined.
module tb_gshare_predictor;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_pc;
  logic       pred_valid;
  logic       pred_taken;
  logic [3:0] pred_index;
  logic       upd_valid;
  logic [3:0] upd_index;
  logic       upd_taken;
  logic [3:0] ghr;
`ifdef PRED_STATS_EN
  logic        upd_pred;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  gshare_predictor #(
    .CTR_WIDTH (2),
    .INDEX_BITS(4),
    .HIST_BITS (4),
    .PC_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_pc    (req_pc),
    .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .pred_index(pred_index),
    .upd_valid (upd_valid),
    .upd_index (upd_index),
    .upd_taken (upd_taken),
`ifdef PRED_STATS_EN
    .upd_pred  (upd_pred),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .ghr       (ghr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    upd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic request(input logic [7:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic update(input logic [3:0] idx, input logic taken);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_taken = taken;
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_pc    = '0;
    upd_valid = 1'b0;
    upd_index = '0;
    upd_taken = 1'b0;
`ifdef PRED_STATS_EN
    upd_pred  = 1'b0;
`endif

    // Request held during reset produces no prediction
    #2;
    req_valid = 1'b1;
    req_pc    = 8'h05;
    tick();
    tick();
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_pred_index", 32'(pred_index), 32'd0);
    check("rst_ghr",        32'(ghr),        32'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("rst_no_pred", 32'(pred_valid), 32'd0);

    // Test 1: first prediction and all entries weakly not-taken
    request(8'h05);
    check("t1_valid", 32'(pred_valid), 32'd1);
    check("t1_taken", 32'(pred_taken), 32'd0);
    check("t1_index", 32'(pred_index), 32'h5);
    check("t1_ghr",   32'(ghr),        32'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_pc = 8'(i);
      tick();
      check("t1_all_valid", 32'(pred_valid), 32'd1);
      check("t1_all_taken", 32'(pred_taken), 32'd0);
      check("t1_all_index", 32'(pred_index), 32'(i));
    end
    req_valid = 1'b0;
    tick();
    check("t1_idle_valid", 32'(pred_valid), 32'd0);
    check("t1_idle_index_hold", 32'(pred_index), 32'hF);

    // Test 2: saturate counter[3] high
    update(4'h3, 1'b1);
    update(4'h3, 1'b1);
    update(4'h3, 1'b1);
    check("t2_ghr_0111", 32'(ghr), 32'h7);
    request(8'h04);
    check("t2_taken", 32'(pred_taken), 32'd1);
    check("t2_index", 32'(pred_index), 32'h3);
    update(4'h3, 1'b1);
    check("t2_ghr_1111", 32'(ghr), 32'hF);
    // 3 -> 3 then one decrement -> 2 still taken; a wrap to 0 would give not-taken
    update(4'h3, 1'b0);
    check("t2_ghr_1110", 32'(ghr), 32'hE);
    request(8'h0D);
    check("t2_sat_taken", 32'(pred_taken), 32'd1);
    check("t2_sat_index", 32'(pred_index), 32'h3);

    // Test 3: saturate counter[0] low
    do_reset();
    update(4'h0, 1'b0);
    update(4'h0, 1'b0);
    check("t3_ghr", 32'(ghr), 32'd0);
    request(8'h00);
    check("t3_taken", 32'(pred_taken), 32'd0);
    check("t3_index", 32'(pred_index), 32'd0);
    update(4'h0, 1'b1);
    request(8'h01);
    check("t3_one_inc_taken", 32'(pred_taken), 32'd0);
    check("t3_one_inc_index", 32'(pred_index), 32'd0);
    update(4'h0, 1'b1);
    check("t3_ghr_0011", 32'(ghr), 32'h3);
    request(8'h03);
    check("t3_two_inc_taken", 32'(pred_taken), 32'd1);
    check("t3_two_inc_index", 32'(pred_index), 32'd0);

    // Test 4: same-cycle request and update on index 2
    do_reset();
    req_valid = 1'b1;
    req_pc    = 8'h02;
    upd_valid = 1'b1;
    upd_index = 4'h2;
    upd_taken = 1'b1;
    tick();
    req_valid = 1'b0;
    upd_valid = 1'b0;
    check("t4_rbw_taken", 32'(pred_taken), 32'd0);
    check("t4_rbw_index", 32'(pred_index), 32'h2);
    check("t4_ghr",       32'(ghr),        32'h1);
    request(8'h03);
    check("t4_after_taken", 32'(pred_taken), 32'd1);
    check("t4_after_index", 32'(pred_index), 32'h2);

    // Test 5: asynchronous reset in the middle of a request burst
    req_valid = 1'b1;
    req_pc    = 8'h03;
    tick();
    check("t5_burst_taken", 32'(pred_taken), 32'd1);
    req_pc = 8'h02;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(pred_valid), 32'd0);
    check("t5_async_taken", 32'(pred_taken), 32'd0);
    check("t5_async_index", 32'(pred_index), 32'd0);
    check("t5_async_ghr",   32'(ghr),        32'd0);
    tick();
    req_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    check("t5_post_valid", 32'(pred_valid), 32'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_pc = 8'(i);
      tick();
      check("t5_init_not_taken", 32'(pred_taken), 32'd0);
    end
    req_valid = 1'b0;
    // One increment per entry must be exactly enough to reach weakly taken
    for (int i = 0; i < 16; i++) update(4'(i), 1'b1);
    check("t5_ghr_ones", 32'(ghr), 32'hF);
    req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_pc = 8'(i ^ 32'hF);
      tick();
      check("t5_inc_taken", 32'(pred_taken), 32'd1);
      check("t5_inc_index", 32'(pred_index), 32'(i));
    end
    req_valid = 1'b0;

`ifdef PRED_STATS_EN
    // Test 6: hit/miss statistics and saturation
    do_reset();
    check("t6_rst_hit",  32'(hit_cnt),  32'd0);
    check("t6_rst_miss", 32'(miss_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'b1;
      upd_index = 4'(i);
      upd_taken = i[0];
      upd_pred  = (i < 3) ? i[0] : ~i[0];
      tick();
    end
    upd_valid = 1'b0;
    check("t6_hit",  32'(hit_cnt),  32'd3);
    check("t6_miss", 32'(miss_cnt), 32'd2);
    do_reset();
    upd_valid = 1'b1;
    upd_taken = 1'b1;
    upd_pred  = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      upd_index = 4'(i);
      tick();
    end
    upd_valid = 1'b0;
    check("t6_hit_sat",  32'(hit_cnt),  32'hFFFF);
    check("t6_miss_sat", 32'(miss_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
Parametrised next-generation branch direction predictor. It replaces the single 2-bit counter with a table of 2^INDEX_BITS saturating counters. The table is indexed by branch PC XOR a global history register (gshare). Sits beside fetch:
- fetch issues requests and receives a registered taken/not-taken prediction plus the table index used;
- execute later returns the resolved outcome with that index to train the table and history.

Parameters:
CTR_WIDTH, 2, width of each saturating counter (>=1)
INDEX_BITS, 4, table depth = 2^INDEX_BITS entries
HIST_BITS, 4, global history length (1..INDEX_BITS)
PC_WIDTH, 8, width of request PC (>=INDEX_BITS)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  prediction request this cycle
req_pc  input  PC_WIDTH  PC of branch being predicted
pred_valid  output  1  prediction outputs valid (one cycle after req_valid)
pred_taken  output  1  predicted direction (1 = taken)
pred_index  output  INDEX_BITS  table index used; returned on upd_index
upd_valid  input  1  resolved branch outcome this cycle
upd_index  input  INDEX_BITS  index originally returned in pred_index
upd_taken  input  1  resolved direction
ghr  output  HIST_BITS  current global history, bit 0 = most recent outcome

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - every counter = 2^(CTR_WIDTH-1)-1 (weakly not-taken; 01 for default);
  - ghr = 0;
  - pred_valid = 0, pred_taken = 0, pred_index = 0.
  - Outstanding requests are discarded; no prediction is emitted for a request accepted in the reset cycle.
- Index: idx = req_pc[INDEX_BITS-1:0] XOR zero-extend(ghr) to INDEX_BITS. Uses the ghr value before any same-cycle shift.
- Prediction latency: 1 cycle, registered.
  - Edge with req_valid=1: pred_valid<=1, pred_taken<=MSB of counter[idx], pred_index<=idx.
  - Edge with req_valid=0: pred_valid<=0; pred_taken/pred_index hold their last values.
- Requests may be issued every cycle. No backpressure; the consumer must sample on pred_valid.
- Update on an edge with upd_valid=1:
  - upd_taken=1: counter[upd_index] increments, saturating at 2^CTR_WIDTH-1.
  - upd_taken=0: counter[upd_index] decrements, saturating at 0.
  - ghr <= {ghr[HIST_BITS-2:0], upd_taken}; for HIST_BITS=1, ghr <= upd_taken.
  - History is non-speculative: it changes only on update.
- Simultaneous request and update in the same cycle:
  - same index: prediction uses the pre-update counter value (read-before-write);
  - different index: independent;
  - history: the request uses the old ghr.
- Saturation boundaries: counter at max with taken stays max; counter at 0 with not-taken stays 0. No wrap-around.
- Out-of-order or repeated updates are legal; each one trains the addressed entry once.
- No X propagation: every output is defined from reset onward.

Optional Feature:
Macro PRED_STATS_EN.
- Defined:
  - adds input upd_pred (1 bit, the direction predicted for this update);
  - adds outputs hit_cnt and miss_cnt, 16 bits each, both reset to 0 by rst_n;
  - each update increments hit_cnt if upd_pred==upd_taken, else miss_cnt;
  - both counters saturate at 16'hFFFF.
- Not defined: these ports and the counter logic are absent; core behaviour is identical.

Test Plan:
1. Reset then req_pc=8'h05 -> next cycle pred_valid=1, pred_taken=0, pred_index=4'h5, ghr=0; after reset, every index predicts 0.
2. Three updates idx 4'h3 taken (ghr becomes 4'b0111) -> request pc=8'h04 (idx=4'h3) gives pred_taken=1; counter[3] saturated at 3; a fourth taken update keeps it at 3.
3. Reset, two updates idx 0 not-taken -> counter[0] stays 0 (no wrap); with ghr=0 a request pc=8'h00 gives pred_taken=0, pred_index=0.
4. Same-cycle request and update on idx 4'h2 (counter=01, upd_taken=1) -> pred_taken=0 from old value; next request on idx 2 gives 1. The index uses the pre-shift ghr.
5. rst_n asserted asynchronously mid-burst of back-to-back requests -> pred_valid, pred_taken, pred_index and ghr go to 0 immediately without a clock edge; all counters read back 01.
6. PRED_STATS_EN defined: 3 updates with upd_pred==upd_taken and 2 mismatched -> hit_cnt=3, miss_cnt=2; 70000 hits from reset -> hit_cnt=16'hFFFF.
